// File: rtl/pcie_ss_csr_lite_pkg.sv
// Shared types for the PCIe SS CSR AXI4-lite responder: response codes, FSM states, grant type.
package pcie_ss_csr_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    B_RESP,
    R_RESP
  } state_t;

  typedef enum logic {
    GNT_WR,
    GNT_RD
  } gnt_t;

endpackage

// File: rtl/ofs_fim_axi_lite_if.sv
// AXI4-lite bundle used between the SS CSR master and its responders.
interface ofs_fim_axi_lite_if #(
  parameter int AWADDR_WIDTH = 20,
  parameter int WDATA_WIDTH  = 32,
  parameter int ARADDR_WIDTH = 20,
  parameter int RDATA_WIDTH  = 32
);
  logic                     awvalid;
  logic                     awready;
  logic [AWADDR_WIDTH-1:0]  awaddr;
  logic                     wvalid;
  logic                     wready;
  logic [WDATA_WIDTH-1:0]   wdata;
  logic [WDATA_WIDTH/8-1:0] wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ARADDR_WIDTH-1:0]  araddr;
  logic                     rvalid;
  logic                     rready;
  logic [RDATA_WIDTH-1:0]   rdata;
  logic [1:0]               rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/pcie_ss_csr_lite_hold.sv
// One-entry valid/ready holding register; ready is registered and low out of reset.
module pcie_ss_csr_lite_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic accept;
  logic full_nxt;

  assign accept = in_valid & in_ready;

  // take only happens while full, when in_ready is already low, so it never races accept
  always_comb begin
    full_nxt = full | accept;
    if (take) full_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      in_ready <= 1'b0;
      data     <= '0;
    end else begin
      full     <= full_nxt;
      in_ready <= ~full_nxt;
      if (accept) data <= in_data;
    end
  end

endmodule

// File: rtl/pcie_ss_csr_lite_slv.sv
// AXI4-lite responder terminating CSR traffic onto a single-outstanding strobe/ack register bus.
module pcie_ss_csr_lite_slv
  import pcie_ss_csr_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 20,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT     = 20'h0_1000,
  parameter int unsigned           TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ofs_fim_axi_lite_if.slave       csr_lite_if,
  output logic                    o_reg_wr,
  output logic                    o_reg_rd,
  output logic [ADDR_WIDTH-1:0]   o_reg_addr,
  output logic [DATA_WIDTH-1:0]   o_reg_wdata,
  output logic [DATA_WIDTH/8-1:0] o_reg_wstrb,
  input  logic                    i_reg_ack,
  input  logic [DATA_WIDTH-1:0]   i_reg_rdata,
  input  logic                    i_reg_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int          W_W   = DATA_WIDTH + DATA_WIDTH / 8;

  state_t state, state_nxt;
  gnt_t   rr_last;
  logic   acc_wr;
  logic [CNT_W-1:0] cnt;

  logic aw_ready, w_ready, ar_ready;
  logic aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [W_W-1:0]        w_held;

  logic wr_pend, rd_pend, gnt_wr, gnt_rd, dec_err, timeout;
  logic [ADDR_WIDTH-1:0] gnt_addr;

  resp_t bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic bvalid, rvalid;

  pcie_ss_csr_lite_hold #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk(clk), .rst_n(rst_n),
    .in_valid(csr_lite_if.awvalid), .in_data(csr_lite_if.awaddr), .in_ready(aw_ready),
    .take(gnt_wr), .full(aw_full), .data(aw_addr)
  );

  pcie_ss_csr_lite_hold #(.WIDTH(W_W)) u_w_hold (
    .clk(clk), .rst_n(rst_n),
    .in_valid(csr_lite_if.wvalid), .in_data({csr_lite_if.wstrb, csr_lite_if.wdata}),
    .in_ready(w_ready),
    .take(gnt_wr), .full(w_full), .data(w_held)
  );

  pcie_ss_csr_lite_hold #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
    .clk(clk), .rst_n(rst_n),
    .in_valid(csr_lite_if.arvalid), .in_data(csr_lite_if.araddr), .in_ready(ar_ready),
    .take(gnt_rd), .full(ar_full), .data(ar_addr)
  );

  // Round-robin: with both pending, the type not granted last wins
  always_comb begin
    wr_pend  = aw_full & w_full;
    rd_pend  = ar_full;
    gnt_rd   = (state == IDLE) & rd_pend & (~wr_pend | (rr_last == GNT_WR));
    gnt_wr   = (state == IDLE) & wr_pend & ~gnt_rd;
    gnt_addr = gnt_rd ? ar_addr : aw_addr;
    dec_err  = (gnt_addr >= ADDR_LIMIT) | (gnt_addr[1:0] != 2'b00);
    timeout  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (gnt_rd)      state_nxt = dec_err ? R_RESP : ACCESS;
        else if (gnt_wr) state_nxt = dec_err ? B_RESP : ACCESS;
      end
      ACCESS: if (i_reg_ack || timeout) state_nxt = acc_wr ? B_RESP : R_RESP;
      B_RESP: if (csr_lite_if.bready) state_nxt = IDLE;
      R_RESP: if (csr_lite_if.rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bvalid = (state == B_RESP);
    rvalid = (state == R_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_reg_wr    <= 1'b0;
      o_reg_rd    <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      o_reg_wstrb <= '0;
      rr_last     <= GNT_WR;
      acc_wr      <= 1'b0;
      cnt         <= '0;
      bresp_q     <= OKAY;
      rresp_q     <= OKAY;
      rdata_q     <= '0;
    end else begin
      o_reg_wr <= gnt_wr & ~dec_err;
      o_reg_rd <= gnt_rd & ~dec_err;
      if (gnt_wr || gnt_rd) begin
        rr_last <= gnt_rd ? GNT_RD : GNT_WR;
        acc_wr  <= gnt_wr;
        cnt     <= '0;
        if (!dec_err) begin
          o_reg_addr <= gnt_addr;
          if (gnt_wr) begin
            o_reg_wdata <= w_held[DATA_WIDTH-1:0];
            o_reg_wstrb <= w_held[DATA_WIDTH +: DATA_WIDTH/8];
          end
        end else if (gnt_rd) begin
          rresp_q <= DECERR;
          rdata_q <= '0;
        end else begin
          bresp_q <= DECERR;
        end
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
        if (i_reg_ack) begin
          if (acc_wr) bresp_q <= i_reg_err ? SLVERR : OKAY;
          else begin
            rresp_q <= i_reg_err ? SLVERR : OKAY;
            rdata_q <= i_reg_rdata;
          end
        end else if (timeout) begin
          if (acc_wr) bresp_q <= SLVERR;
          else begin
            rresp_q <= SLVERR;
            rdata_q <= '0;
          end
        end
      end
    end
  end

  assign csr_lite_if.awready = aw_ready;
  assign csr_lite_if.wready  = w_ready;
  assign csr_lite_if.arready = ar_ready;
  assign csr_lite_if.bvalid  = bvalid;
  assign csr_lite_if.bresp   = bresp_q;
  assign csr_lite_if.rvalid  = rvalid;
  assign csr_lite_if.rresp   = rresp_q;
  assign csr_lite_if.rdata   = rdata_q;

endmodule

// File: tb/tb_pcie_ss_csr_lite_slv.sv
// Self-checking bench: directed scenarios plus random transactions against a response model.
module tb_pcie_ss_csr_lite_slv;

  localparam int unsigned TO = 16;
  localparam logic [1:0] R_OKAY = 2'b00, R_SLVERR = 2'b10, R_DECERR = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ofs_fim_axi_lite_if #(.AWADDR_WIDTH(20), .WDATA_WIDTH(32), .ARADDR_WIDTH(20), .RDATA_WIDTH(32)) axi ();

  logic        o_reg_wr, o_reg_rd;
  logic [19:0] o_reg_addr;
  logic [31:0] o_reg_wdata;
  logic [3:0]  o_reg_wstrb;
  logic        i_reg_ack;
  logic [31:0] i_reg_rdata;
  logic        i_reg_err;

  pcie_ss_csr_lite_slv #(
    .ADDR_WIDTH(20), .DATA_WIDTH(32), .ADDR_LIMIT(20'h0_1000), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csr_lite_if(axi),
    .o_reg_wr(o_reg_wr), .o_reg_rd(o_reg_rd), .o_reg_addr(o_reg_addr),
    .o_reg_wdata(o_reg_wdata), .o_reg_wstrb(o_reg_wstrb),
    .i_reg_ack(i_reg_ack), .i_reg_rdata(i_reg_rdata), .i_reg_err(i_reg_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor of the local bus and AXI response channels
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, strobe_cyc = 0;
  logic [19:0] st_addr = '0;
  logic [31:0] st_wdata = '0;
  logic [3:0]  st_wstrb = '0;
  logic        both_valid = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_reg_wr) begin
      wr_cnt <= wr_cnt + 1; strobe_cyc <= cyc;
      st_addr <= o_reg_addr; st_wdata <= o_reg_wdata; st_wstrb <= o_reg_wstrb;
    end
    if (o_reg_rd) begin
      rd_cnt <= rd_cnt + 1; strobe_cyc <= cyc; st_addr <= o_reg_addr;
    end
    if (axi.bvalid && axi.rvalid) both_valid <= 1'b1;
  end

  // Local register responder: ack ack_dly cycles after each strobe unless no_ack
  int          ack_dly = 2;
  logic        no_ack = 1'b0, err_mode = 1'b0;
  logic [31:0] cfg_rdata = '0;
  logic        resp_ack = 1'b0, late_ack = 1'b0;
  assign i_reg_ack   = resp_ack | late_ack;
  assign i_reg_rdata = cfg_rdata;
  assign i_reg_err   = err_mode;

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && (o_reg_wr || o_reg_rd) && !no_ack) begin
        repeat (ack_dly - 1) @(posedge clk);
        #1 resp_ack = 1'b1;
        @(posedge clk);
        #1 resp_ack = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_resp(input logic [19:0] a, input logic nack, input logic err);
    if (a >= 20'h0_1000 || a[1:0] != 2'b00) return R_DECERR;
    if (nack || err) return R_SLVERR;
    return R_OKAY;
  endfunction

  task automatic send_req(input logic do_aw, input logic do_w, input logic do_ar,
                          input logic [19:0] aw_a, input logic [31:0] d, input logic [3:0] s,
                          input logic [19:0] ar_a);
    logic p_aw, p_w, p_ar, a_aw, a_w, a_ar;
    p_aw = do_aw; p_w = do_w; p_ar = do_ar;
    if (do_aw) begin axi.awaddr = aw_a; axi.awvalid = 1'b1; end
    if (do_w)  begin axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1; end
    if (do_ar) begin axi.araddr = ar_a; axi.arvalid = 1'b1; end
    for (int i = 0; i < 100 && (p_aw || p_w || p_ar); i++) begin
      a_aw = p_aw && axi.awready;
      a_w  = p_w  && axi.wready;
      a_ar = p_ar && axi.arready;
      tick();
      if (a_aw) begin p_aw = 1'b0; axi.awvalid = 1'b0; end
      if (a_w)  begin p_w  = 1'b0; axi.wvalid  = 1'b0; end
      if (a_ar) begin p_ar = 1'b0; axi.arvalid = 1'b0; end
    end
    check_eq("req_accept", {p_aw, p_w, p_ar}, 3'b000);
  endtask

  task automatic wait_resp(input logic is_wr, input int hold, output logic [1:0] resp,
                           output logic [31:0] rdata, output int vcyc);
    int n;
    n = 0;
    while (!(is_wr ? axi.bvalid : axi.rvalid) && n < 400) begin
      tick();
      n++;
    end
    check_eq(is_wr ? "bvalid_seen" : "rvalid_seen", n < 400, 1);
    vcyc  = cyc;
    resp  = is_wr ? axi.bresp : axi.rresp;
    rdata = axi.rdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (is_wr) check_eq("bvalid_hold", {axi.bvalid, axi.bresp}, {1'b1, resp});
      else       check_eq("rvalid_hold", {axi.rvalid, axi.rresp, axi.rdata}, {1'b1, resp, rdata});
    end
    if (is_wr) axi.bready = 1'b1; else axi.rready = 1'b1;
    tick();
    axi.bready = 1'b0;
    axi.rready = 1'b0;
  endtask

  task automatic run_txn(input string tag, input logic is_wr, input logic [19:0] a,
                         input logic [31:0] d, input logic [3:0] s, input int dly,
                         input logic err, input logic nack, input logic [31:0] rdv, input int hold);
    int wr0, rd0, vcyc;
    logic dec;
    logic [1:0] resp;
    logic [31:0] rdat;
    wr0 = wr_cnt; rd0 = rd_cnt;
    ack_dly = dly; err_mode = err; no_ack = nack; cfg_rdata = rdv;
    dec = (a >= 20'h0_1000) || (a[1:0] != 2'b00);
    if (is_wr) send_req(1'b1, 1'b1, 1'b0, a, d, s, '0);
    else       send_req(1'b0, 1'b0, 1'b1, '0, '0, '0, a);
    wait_resp(is_wr, hold, resp, rdat, vcyc);
    check_eq({tag, "_resp"}, resp, model_resp(a, nack, err));
    if (!is_wr) check_eq({tag, "_rdata"}, rdat, (dec || nack) ? 32'h0 : rdv);
    check_eq({tag, "_strobes"}, {wr_cnt - wr0, rd_cnt - rd0},
             {(is_wr && !dec) ? 32'd1 : 32'd0, (!is_wr && !dec) ? 32'd1 : 32'd0});
    if (!dec) begin
      check_eq({tag, "_addr"}, st_addr, a);
      if (is_wr) check_eq({tag, "_wdata"}, {st_wstrb, st_wdata}, {s, d});
      check_eq({tag, "_latency"}, vcyc - strobe_cyc, nack ? TO : dly + 1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    axi.bready = 1'b0; axi.rready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int wr0, rd0, vcyc, n;
    logic [1:0] resp;
    logic [31:0] rdat;
    logic saw;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    axi.bready = 1'b0; axi.rready = 1'b0;
    axi.awaddr = '0; axi.araddr = '0; axi.wdata = '0; axi.wstrb = '0;
    #2 rst_n = 1'b0;
    tick(); tick();
    check_eq("reset_ctrl", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid,
                            o_reg_wr, o_reg_rd}, 7'b0);
    check_eq("reset_data", {o_reg_addr, o_reg_wdata, o_reg_wstrb, axi.bresp, axi.rresp, axi.rdata}, '0);
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_reset", {axi.awready, axi.wready, axi.arready}, 3'b111);

    run_txn("t1_write", 1'b1, 20'h010, 32'hA5A5_0001, 4'hF, 3, 1'b0, 1'b0, 32'h0, 5);
    run_txn("t2_read_err", 1'b0, 20'h020, 32'h0, 4'h0, 2, 1'b1, 1'b0, 32'h1234_5678, 1);

    // W leads AW by four cycles
    wr0 = wr_cnt; ack_dly = 2; err_mode = 1'b0; no_ack = 1'b0;
    axi.wdata = 32'h0BAD_F00D; axi.wstrb = 4'h3; axi.wvalid = 1'b1;
    check_eq("t3_wready_first", axi.wready, 1'b1);
    tick();
    axi.wvalid = 1'b0;
    repeat (3) tick();
    check_eq("t3_no_early_strobe", wr_cnt - wr0, 0);
    send_req(1'b1, 1'b0, 1'b0, 20'h040, '0, '0, '0);
    wait_resp(1'b1, 0, resp, rdat, vcyc);
    check_eq("t3_resp", resp, R_OKAY);
    check_eq("t3_data", {wr_cnt - wr0, st_addr, st_wstrb, st_wdata}, {32'd1, 20'h040, 4'h3, 32'h0BAD_F00D});

    // Arbitration from reset: read first, then write; a second read queued behind loses to the write
    do_reset();
    wr0 = wr_cnt; rd0 = rd_cnt; ack_dly = 1; err_mode = 1'b0; no_ack = 1'b0; cfg_rdata = 32'hCAFE_0004;
    send_req(1'b1, 1'b1, 1'b1, 20'h100, 32'h1111_2222, 4'hF, 20'h104);
    send_req(1'b0, 1'b0, 1'b1, '0, '0, '0, 20'h108);
    wait_resp(1'b0, 0, resp, rdat, vcyc);
    check_eq("t4_read_first", {wr_cnt - wr0, rd_cnt - rd0, rdat}, {32'd0, 32'd1, 32'hCAFE_0004});
    wait_resp(1'b1, 0, resp, rdat, vcyc);
    check_eq("t4_write_second", {wr_cnt - wr0, rd_cnt - rd0, st_addr}, {32'd1, 32'd1, 20'h100});
    wait_resp(1'b0, 0, resp, rdat, vcyc);
    check_eq("t4_read_third", {wr_cnt - wr0, rd_cnt - rd0, st_addr}, {32'd1, 32'd2, 20'h108});

    run_txn("t5_rd_oor", 1'b0, 20'h01000, 32'h0, 4'h0, 1, 1'b0, 1'b0, 32'hFFFF_FFFF, 0);
    run_txn("t5_wr_unal", 1'b1, 20'h00006, 32'h5555_AAAA, 4'hF, 1, 1'b0, 1'b0, 32'h0, 0);
    run_txn("t6_timeout", 1'b0, 20'h0080, 32'h0, 4'h0, 1, 1'b0, 1'b1, 32'h7777_7777, 0);

    // Late ack in IDLE must not produce a response
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (axi.bvalid || axi.rvalid) saw = 1'b1;
    end
    check_eq("t6_late_ack_quiet", saw, 1'b0);

    // Reset during ACCESS
    rd0 = rd_cnt; no_ack = 1'b1;
    send_req(1'b0, 1'b0, 1'b1, '0, '0, '0, 20'h030);
    n = 0;
    while (rd_cnt == rd0 && n < 20) begin tick(); n++; end
    check_eq("t7_in_access", rd_cnt - rd0, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t7_reset_outputs", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid,
                                  o_reg_wr, o_reg_rd}, 7'b0);
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (axi.bvalid || axi.rvalid) saw = 1'b1;
    end
    check_eq("t7_dropped", saw, 1'b0);
    run_txn("t7_after", 1'b0, 20'h034, 32'h0, 4'h0, 2, 1'b0, 1'b0, 32'h00C0_FFEE, 0);

    for (int k = 0; k < 40; k++) begin
      logic        wr;
      logic [19:0] a;
      int          sel;
      wr  = 1'($urandom % 2);
      sel = int'($urandom % 8);
      if (sel == 0)      a = 20'h0_1000 + 20'($urandom_range(0, 'hFFF));
      else if (sel == 1) a = {8'h0, 10'($urandom_range(0, 'h3FF)), 2'($urandom_range(1, 3))};
      else               a = {8'h0, 10'($urandom_range(0, 'h3FF)), 2'b00};
      run_txn("rnd", wr, a, $urandom, 4'($urandom), int'($urandom_range(1, 5)),
              1'($urandom % 4 == 0), 1'($urandom % 10 == 0), $urandom, int'($urandom % 3));
    end

    check_eq("never_both_valid", both_valid, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
